counter_ctrl: RTL
=================

# counter_ctrl

Run-control sequencer for a small synchronous up/down counter datapath on the board-level top. It turns level switch inputs into start/stop edges and runs a state machine that drives the counter's load, enable and direction controls. Modes are continuous up, continuous down, ping-pong and one-shot. Count, status and terminal-count pulses go to LEDs and the LCD debug bus.

## Interface
- NBITS_COUNT, 2, counter width; MAX = 2**NBITS_COUNT-1
- clk_2  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  level; rising edge requests run/resume/restart
- stop  in  1  level; rising edge requests pause/abort
- mode  in  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 one-shot up
- load_en  in  1  preload load_value when starting from IDLE or DONE
- load_value  in  NBITS_COUNT  preload value
- count  out  NBITS_COUNT  counter value, registered
- busy  out  1  high in LOAD or RUN
- paused  out  1  high in PAUSE
- done  out  1  high in DONE
- dir_up  out  1  current count direction
- tc  out  1  one-cycle terminal-count pulse

## Operation
- Edge detect:
  - start_q/stop_q register start/stop each cycle; start_rise = start & ~start_q, likewise stop_rise.
  - start_q and stop_q reset to 1, so an input held high through reset produces no edge.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE:
  - Counter holds.
  - On start_rise, go to LOAD if load_en, else go to RUN.
  - Either way, dir_up is set to 0 for mode 01 and to 1 otherwise.
- LOAD: lasts one cycle; count <= load_value; then RUN unconditionally.
- RUN, one counter step per cycle, with the mode sampled every cycle:
  - 00: count+1, MAX wraps to 0; tc when stepping from MAX.
  - 01: count-1, 0 wraps to MAX; tc when stepping from 0.
  - 10, dir_up=1:
    - If count==MAX, step to MAX-1, clear dir_up and pulse tc.
    - Otherwise step +1.
    - Down direction is symmetric at 0.
    - Sequence for width 2: 0,1,2,3,2,1,0,1...
  - 11:
    - If count==MAX, count holds, tc pulses and the state goes to DONE.
    - Otherwise step +1.
  - A mode switch into 00, 01 or 11 while running forces dir_up to match the mode on the same cycle.
- Exits from RUN:
  - stop_rise: go to PAUSE, count holds; no step that cycle.
  - start_rise: ignored.
- PAUSE:
  - start_rise resumes RUN with count and dir_up retained and no reload.
  - stop_rise goes to IDLE with count retained.
- DONE:
  - Count holds; done=1.
  - start_rise goes to LOAD, loading load_en ? load_value : 0.
  - stop_rise goes to IDLE.
- Simultaneous start_rise and stop_rise: stop wins in every state (IDLE stays IDLE).
- load_value is sampled only in the LOAD cycle.

## Timing
- Reset values: state IDLE, count 0, dir_up 1, busy/paused/done/tc 0, start_q/stop_q 1.
- An edge sampled at clock edge k changes the state at edge k. Outputs reflect the new state after k.
- LOAD adds one cycle: the first RUN step lands two edges after start_rise.
- tc is asserted in the cycle after the qualifying step's edge, for exactly one cycle.
  - In one-shot mode, tc and done rise together.
- count updates only in LOAD and RUN. No count-update path exists in IDLE, PAUSE or DONE.
- Reset mid-run: immediate return to reset values, independent of the clock.

## Structure
- counter_ctrl_pkg holds:
  - state_t enum: IDLE, LOAD, RUN, PAUSE, DONE.
  - mode_t enum: MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_ONESHOT.
- Sub-module updown_counter:
  - Ports: clk_2, reset, load, en, up, d, q.
  - Priority load > en; wraps naturally.
  - Instantiated once.
- counter_ctrl holds the edge detectors, the FSM, dir_up and the tc/terminal logic. It drives updown_counter.load/en/up/d.

## Test plan
- Reset with start held high, then release reset, hold start: state stays IDLE, count 0. Drop start, then raise it: RUN, count 1 after the first RUN edge.
- Mode 00 from 0, 8 RUN cycles: count 1,2,3,0,1,2,3,0. tc in the cycle count becomes 0 after each wrap.
- Mode 10 from load_value 2, load_en=1:
  - start gives LOAD with count 2.
  - RUN gives 3,2,1,0,1. dir_up drops after 3 and rises after 0.
  - tc pulses at both turnarounds.
- Mode 11 from 0: count 1,2,3, then DONE with done=1 and count held at 3 for 5 cycles. start_rise with load_en=0 gives count 0, then RUN.
- RUN in mode 01 at count 2: stop_rise gives PAUSE with count 2 held 4 cycles. start_rise resumes with 1,0,3. A second stop then stop gives IDLE.
- start and stop rise on the same edge from IDLE, RUN and PAUSE: stop wins (IDLE, PAUSE, IDLE). Async reset asserted mid-RUN: count 0, busy 0 without waiting for a clock edge.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter run-control sequencer: FSM states, count modes
// and the direction a fresh run starts in.
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_t;

  // Only the down-wrap mode starts counting downwards; ping-pong starts up.
  function automatic logic start_dir(input mode_t m);
    return (m != MODE_DOWN);
  endfunction

endpackage

// File: rtl/counter_ctrl_updown.sv
// Plain up/down counter with synchronous load; load has priority over enable
// and the count wraps naturally at both ends.
module updown_counter #(
  parameter int NBITS = 2
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [NBITS-1:0] d,
  output logic [NBITS-1:0] q
);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= up ? q + 1'b1 : q - 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run-control sequencer: edge-detects start/stop, sequences IDLE/LOAD/RUN/
// PAUSE/DONE and steers the up/down counter's load, enable and direction.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int NBITS_COUNT = 2
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic                   load_en,
  input  logic [NBITS_COUNT-1:0] load_value,
  output logic [NBITS_COUNT-1:0] count,
  output logic                   busy,
  output logic                   paused,
  output logic                   done,
  output logic                   dir_up,
  output logic                   tc,
  output logic [2:0]             o_dbg_state
);

  localparam logic [NBITS_COUNT-1:0] MAX  = '1;
  localparam logic [NBITS_COUNT-1:0] ZERO = '0;

  state_t                   r_state;
  logic                     r_start_q;
  logic                     r_stop_q;
  logic                     r_dir_up;
  logic                     r_tc;
  logic                     r_busy;
  logic                     r_paused;
  logic                     r_done;
  logic                     r_load_zero;

  mode_t                    w_mode;
  logic                     w_start_rise;
  logic                     w_stop_rise;
  state_t                   w_next_state;
  logic                     w_dir_next;
  logic                     w_tc_next;
  logic                     w_load_zero_next;
  logic                     w_cnt_load;
  logic                     w_cnt_en;
  logic                     w_cnt_up;
  logic [NBITS_COUNT-1:0]   w_cnt_d;

  assign w_mode       = mode_t'(mode);
  assign w_start_rise = start & ~r_start_q;
  assign w_stop_rise  = stop & ~r_stop_q;

  // Stop has priority over start in every state.
  always_comb begin
    w_next_state     = r_state;
    w_dir_next       = r_dir_up;
    w_tc_next        = 1'b0;
    w_load_zero_next = r_load_zero;
    w_cnt_load       = 1'b0;
    w_cnt_en         = 1'b0;
    w_cnt_up         = r_dir_up;
    w_cnt_d          = r_load_zero ? ZERO : load_value;
    case (r_state)
      IDLE: begin
        if (!w_stop_rise && w_start_rise) begin
          w_next_state     = load_en ? LOAD : RUN;
          w_dir_next       = start_dir(w_mode);
          w_load_zero_next = 1'b0;
        end
      end
      LOAD: begin
        w_cnt_load   = 1'b1;
        w_next_state = RUN;
      end
      RUN: begin
        if (w_stop_rise) begin
          w_next_state = PAUSE;
        end else begin
          w_cnt_en = 1'b1;
          case (w_mode)
            MODE_UP: begin
              w_cnt_up   = 1'b1;
              w_dir_next = 1'b1;
              w_tc_next  = (count == MAX);
            end
            MODE_DOWN: begin
              w_cnt_up   = 1'b0;
              w_dir_next = 1'b0;
              w_tc_next  = (count == ZERO);
            end
            MODE_PINGPONG: begin
              if (r_dir_up) begin
                w_cnt_up = (count != MAX);
                if (count == MAX) begin
                  w_dir_next = 1'b0;
                  w_tc_next  = 1'b1;
                end
              end else begin
                w_cnt_up = (count == ZERO);
                if (count == ZERO) begin
                  w_dir_next = 1'b1;
                  w_tc_next  = 1'b1;
                end
              end
            end
            MODE_ONESHOT: begin
              w_cnt_up   = 1'b1;
              w_dir_next = 1'b1;
              if (count == MAX) begin
                w_cnt_en     = 1'b0;
                w_tc_next    = 1'b1;
                w_next_state = DONE;
              end
            end
          endcase
        end
      end
      PAUSE: begin
        if (w_stop_rise) begin
          w_next_state = IDLE;
        end else if (w_start_rise) begin
          w_next_state = RUN;
        end
      end
      DONE: begin
        if (w_stop_rise) begin
          w_next_state = IDLE;
        end else if (w_start_rise) begin
          w_next_state     = LOAD;
          w_dir_next       = start_dir(w_mode);
          w_load_zero_next = ~load_en;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_start_q   <= 1'b1;
      r_stop_q    <= 1'b1;
      r_dir_up    <= 1'b1;
      r_tc        <= 1'b0;
      r_busy      <= 1'b0;
      r_paused    <= 1'b0;
      r_done      <= 1'b0;
      r_load_zero <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_start_q   <= start;
      r_stop_q    <= stop;
      r_dir_up    <= w_dir_next;
      r_tc        <= w_tc_next;
      r_busy      <= (w_next_state == LOAD) || (w_next_state == RUN);
      r_paused    <= (w_next_state == PAUSE);
      r_done      <= (w_next_state == DONE);
      r_load_zero <= w_load_zero_next;
    end
  end

  updown_counter #(
    .NBITS(NBITS_COUNT)
  ) u_counter (
    .clk_2(clk_2),
    .reset(reset),
    .load (w_cnt_load),
    .en   (w_cnt_en),
    .up   (w_cnt_up),
    .d    (w_cnt_d),
    .q    (count)
  );

  assign busy        = r_busy;
  assign paused      = r_paused;
  assign done        = r_done;
  assign dir_up      = r_dir_up;
  assign tc          = r_tc;
  assign o_dbg_state = r_state;

endmodule
